// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared FIFO package (package fifo_pkg): default geometry plus Gray-code
// helpers. The read-side controller reuses the same defaults and helpers.
package fifo_pkg;

   localparam int DATA_WIDTH_DEF   = 8;
   localparam int ADDR_WIDTH_DEF   = 3;
   localparam int AFULL_THRESH_DEF = 6;

   // Binary to reflected Gray; callers zero-extend in and size-cast out.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary; bits above the caller's width are zero and stay zero.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side FIFO bus: producer handshake, memory write port and the
// pointer exchange with the read domain. The almost_full signal exists only
// when FIFO_ALMOST_FULL_EN is defined.
interface fifo_wr_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  winc;
   logic [DATA_WIDTH-1:0] wdata_in;
   logic [ADDR_WIDTH:0]   rptr_gray;
   logic                  wclken;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [ADDR_WIDTH:0]   wptr_gray;
   logic                  full;
   logic                  overflow;
`ifdef FIFO_ALMOST_FULL_EN
   logic                  almost_full;

   modport master (output winc, wdata_in, rptr_gray,
                   input  wclken, waddr, wdata, wptr_gray, full, overflow, almost_full);
   modport slave  (input  winc, wdata_in, rptr_gray,
                   output wclken, waddr, wdata, wptr_gray, full, overflow, almost_full);
`else
   modport master (output winc, wdata_in, rptr_gray,
                   input  wclken, waddr, wdata, wptr_gray, full, overflow);
   modport slave  (input  winc, wdata_in, rptr_gray,
                   output wclken, waddr, wdata, wptr_gray, full, overflow);
`endif
endinterface

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into CLK's domain.
// Only one bit changes per pointer step, so a multi-bit Gray word is safe.
module fifo_ptr_sync #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] meta;

   // Two-stage capture; output lags the input by two rising edges.
   always_ff @(posedge CLK) begin
      if (RST) begin
         meta <= '0;
         dout <= '0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: binary/Gray write pointer, read
// pointer synchronizer, registered full flag and sticky overflow.
// Optional feature macro: FIFO_ALMOST_FULL_EN (registered almost_full).
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   fifo_wr_ctrl_if.slave bus
);
   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] wgray_next;
   logic [PW-1:0] rq2;
   logic [PW-1:0] full_match;
   logic          full_q;
   logic          full_next;
   logic          ovf_q;
   logic          wclken;

   fifo_ptr_sync #(.WIDTH(PW)) u_rptr_sync (
      .CLK  (CLK),
      .RST  (RST),
      .din  (bus.rptr_gray),
      .dout (rq2)
   );

   // The only write path: blocked while full or in reset.
   assign wclken = bus.winc & ~full_q & ~RST;

   assign wbin_next  = wbin + PW'(wclken);
   assign wgray_next = PW'(bin2gray(32'(wbin_next)));

   // Full when the write pointer is exactly one lap ahead of the (stale)
   // read pointer: top two Gray bits inverted, the rest equal. The stale
   // read pointer makes this pessimistic, never optimistic.
   assign full_match = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
   assign full_next  = (wgray_next == full_match);

   // Pointer, full and sticky overflow state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wbin           <= '0;
         bus.wptr_gray  <= '0;
         full_q         <= 1'b0;
         ovf_q          <= 1'b0;
      end else begin
         wbin           <= wbin_next;
         bus.wptr_gray  <= wgray_next;
         full_q         <= full_next;
         if (bus.winc && full_q) ovf_q <= 1'b1;
      end
   end

`ifdef FIFO_ALMOST_FULL_EN
   logic [PW-1:0] rbin;
   logic [PW-1:0] occ;
   localparam logic [PW-1:0] AF_THRESH = PW'(AFULL_THRESH);

   assign rbin = PW'(gray2bin(32'(rq2)));
   assign occ  = wbin_next - rbin;

   // Occupancy against the synchronized read pointer, registered.
   always_ff @(posedge CLK) begin
      if (RST) bus.almost_full <= 1'b0;
      else     bus.almost_full <= (occ >= AF_THRESH);
   end
`endif

   assign bus.wclken   = wclken;
   assign bus.waddr    = wbin[ADDR_WIDTH-1:0];
   assign bus.wdata    = bus.wdata_in;
   assign bus.full     = full_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: reset, fill, overflow, drain release,
// pointer wrap and (with FIFO_ALMOST_FULL_EN) the almost_full threshold.
module tb_fifo_wr_ctrl;
   logic CLK = 1'b0;
   logic RST;
   int   vectors    = 0;
   int   miscompares = 0;

   logic [3:0] GRAY [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                             4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

   fifo_wr_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

   fifo_wr_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // Reset with a write request pending
      RST = 1'b1;
      bus.winc = 1'b1;
      bus.wdata_in = 8'h00;
      bus.rptr_gray = 4'd0;
      #1;
      check("rst_wclken_during", 32'(bus.wclken), 32'd0);
      tick();
      check("rst_wclken", 32'(bus.wclken), 32'd0);
      check("rst_waddr", 32'(bus.waddr), 32'd0);
      check("rst_wptr_gray", 32'(bus.wptr_gray), 32'd0);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      RST = 1'b0;

      // Fill eight slots with the reader parked at 0
      for (int i = 0; i < 8; i++) begin
         bus.wdata_in = 8'(8'h10 + i);
         #1;
         check("fill_wclken", 32'(bus.wclken), 32'd1);
         check("fill_waddr", 32'(bus.waddr), 32'(i));
         check("fill_wdata", 32'(bus.wdata), 32'(8'h10 + i));
         check("fill_full_before", 32'(bus.full), 32'd0);
         tick();
      end
      check("fill_full", 32'(bus.full), 32'd1);
      check("fill_wptr_gray", 32'(bus.wptr_gray), 32'b1100);

      // Write while full is dropped and sets overflow
      #1;
      check("ovf_wclken", 32'(bus.wclken), 32'd0);
      check("ovf_waddr", 32'(bus.waddr), 32'd0);
      tick();
      check("ovf_flag", 32'(bus.overflow), 32'd1);
      check("ovf_full", 32'(bus.full), 32'd1);
      check("ovf_wptr_held", 32'(bus.wptr_gray), 32'b1100);
      bus.winc = 1'b0;

      // Reader frees one slot; full releases on the third edge
      bus.rptr_gray = 4'b0001;
      tick();
      check("drain_full_e1", 32'(bus.full), 32'd1);
      tick();
      check("drain_full_e2", 32'(bus.full), 32'd1);
      tick();
      check("drain_full_e3", 32'(bus.full), 32'd0);
      check("drain_ovf_sticky", 32'(bus.overflow), 32'd1);
      bus.winc = 1'b1;
      bus.wdata_in = 8'hAA;
      #1;
      check("drain_wclken", 32'(bus.wclken), 32'd1);
      check("drain_waddr", 32'(bus.waddr), 32'd0);
      tick();
      check("drain_wptr_gray9", 32'(bus.wptr_gray), 32'b1101);
      check("drain_full_again", 32'(bus.full), 32'd1);
      bus.winc = 1'b0;

      // Reset clears the sticky overflow
      RST = 1'b1;
      bus.rptr_gray = 4'd0;
      tick();
      RST = 1'b0;
      check("rst2_overflow", 32'(bus.overflow), 32'd0);
      check("rst2_full", 32'(bus.full), 32'd0);

      // Twenty writes with the reader two pointers behind: wrap, no full
      for (int k = 0; k < 20; k++) begin
         bus.rptr_gray = (k >= 2) ? GRAY[(k - 2) % 16] : 4'd0;
         bus.winc = 1'b1;
         bus.wdata_in = 8'(k);
         #1;
         check("wrap_wclken", 32'(bus.wclken), 32'd1);
         check("wrap_waddr", 32'(bus.waddr), 32'(k % 8));
         tick();
         check("wrap_wptr_gray", 32'(bus.wptr_gray), 32'(GRAY[(k + 1) % 16]));
         check("wrap_full", 32'(bus.full), 32'd0);
      end
      bus.winc = 1'b0;
      check("wrap_overflow", 32'(bus.overflow), 32'd0);

`ifdef FIFO_ALMOST_FULL_EN
      // Almost-full threshold at six outstanding writes
      RST = 1'b1;
      bus.rptr_gray = 4'd0;
      tick();
      RST = 1'b0;
      check("af_rst", 32'(bus.almost_full), 32'd0);
      bus.winc = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("af_after5", 32'(bus.almost_full), 32'd0);
      tick();
      check("af_after6", 32'(bus.almost_full), 32'd1);
      bus.winc = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the write data word passed to the FIFO memory.
REQ-002 Parameter ADDR_WIDTH, default 3, memory address width; depth = 2**ADDR_WIDTH (8).
REQ-003 Parameter AFULL_THRESH, default 6, occupancy at or above which almost_full asserts.
REQ-004 CLK  input  1  write-domain clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 winc  input  1  write request from producer.
REQ-007 wdata_in  input  DATA_WIDTH  producer write data.
REQ-008 rptr_gray  input  ADDR_WIDTH+1  Gray read pointer from the read domain, unsynchronized.
REQ-009 wclken  output  1  memory write enable.
REQ-010 waddr  output  ADDR_WIDTH  memory write address.
REQ-011 wdata  output  DATA_WIDTH  memory write data, equal to wdata_in combinationally.
REQ-012 wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer for the read domain.
REQ-013 full  output  1  registered FIFO-full flag.
REQ-014 overflow  output  1  sticky flag: write attempted while full.
REQ-015 almost_full  output  1  registered; present only under FIFO_ALMOST_FULL_EN.

Function
REQ-016 wclken SHALL equal winc AND NOT full, combinationally; no other write path exists.
REQ-017 waddr SHALL equal the low ADDR_WIDTH bits of the binary write pointer wbin (ADDR_WIDTH+1 bits).
REQ-018 On each cycle with wclken=1, wbin SHALL increment by 1 modulo 2**(ADDR_WIDTH+1); wraps 15->0 for default width.
REQ-019 wptr_gray SHALL be registered as wbin_next XOR (wbin_next >> 1), updating in the same edge as wbin.
REQ-020 rptr_gray SHALL pass through a two-flop synchronizer on CLK; the synchronized value rq2 lags the input by 2 cycles.
REQ-021 full SHALL register (gray(wbin_next) == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}); asserts on the edge completing the DEPTH-th unread write.
REQ-022 full SHALL deassert no earlier than 2 cycles after rptr_gray advances (pessimistic, never optimistic).
REQ-023 winc while full SHALL drop the write (wclken=0, pointer held) and set overflow; overflow clears only on RST.
REQ-024 Simultaneous winc and read-pointer advance while full: write SHALL be dropped in that cycle; the freed slot is usable only once full deasserts.
REQ-025 Empty is not computed here; read side owns it.

Reset
REQ-026 On RST=1 at a rising edge: wbin=0, wptr_gray=0, both synchronizer stages=0, full=0, overflow=0, almost_full=0.
REQ-027 During RST=1, wclken SHALL be 0 regardless of winc; a write in progress is abandoned without pointer update.
REQ-028 Reset mid-operation SHALL be assumed coordinated with the read-side reset; no pointer recovery is provided.

Configuration
REQ-029 Macro FIFO_ALMOST_FULL_EN: when defined, almost_full SHALL register (wbin_next - gray2bin(rq2)) mod 2**(ADDR_WIDTH+1) >= AFULL_THRESH.
REQ-030 When FIFO_ALMOST_FULL_EN is undefined, the almost_full port, gray-to-binary converter and subtractor SHALL be absent.

Structure
REQ-031 Shared package fifo_pkg SHALL hold default DATA_WIDTH, ADDR_WIDTH, AFULL_THRESH and bin-to-Gray / Gray-to-bin functions, reused by the read-side controller.
REQ-032 One sub-module fifo_ptr_sync (parameterized-width two-flop synchronizer, sync active-high reset) SHALL be instantiated for rptr_gray.

Verification
REQ-033 Reset: RST=1 one cycle with winc=1 -> wclken=0, waddr=0, wptr_gray=0, full=0, overflow=0.
REQ-034 Fill: rptr_gray=0, winc=1 for 8 cycles, wdata_in=0x10..0x17 -> waddr 0..7, wclken=1 each cycle, full=1 after 8th edge, wptr_gray=4'b1100.
REQ-035 Overflow: from full, winc=1 one cycle -> wclken=0, waddr held 0, overflow=1 and stays 1 until RST.
REQ-036 Drain release: from full, rptr_gray 0->1 -> full stays 1 for 2 edges, falls on 3rd; next winc writes waddr=0 with wbin=8.
REQ-037 Wrap: 20 writes interleaved with rptr_gray tracking 2 cycles behind -> wbin wraps 15->0, wptr_gray sequence Gray-correct, full never asserts, overflow=0.
REQ-038 FIFO_ALMOST_FULL_EN defined: rptr_gray=0, 6 writes -> almost_full=1 after 6th edge, 0 after 5; undefined build compiles without the port.
